// File: rtl/dm_master_pkg.sv
// Shared definitions for the data-memory master.
//   op_e      : CPU load/store operation encoding carried on req_op
//   state_e   : master FSM states
//   DEFAULT_ADDR_LIMIT : default exclusive upper bound of data memory
//   is_load / access_error : request classification helpers
package dm_master_pkg;

    localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0000_3000;

    typedef enum logic [2:0] {
        OpLw  = 3'd0,
        OpLh  = 3'd1,
        OpLhu = 3'd2,
        OpLb  = 3'd3,
        OpLbu = 3'd4,
        OpSw  = 3'd5,
        OpSh  = 3'd6,
        OpSb  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWrite  = 2'd2,
        StResp   = 2'd3
    } state_e;

    function automatic logic is_load(op_e op);
        return (op == OpLw) || (op == OpLh) || (op == OpLhu) || (op == OpLb) || (op == OpLbu);
    endfunction

    // Out of range, or halfword/word not naturally aligned.
    function automatic logic access_error(op_e op, logic [31:0] addr, logic [31:0] limit);
        logic half, word;
        half = (op == OpLh) || (op == OpLhu) || (op == OpSh);
        word = (op == OpLw) || (op == OpSw);
        return (addr >= limit) || (half && addr[0]) || (word && (addr[1:0] != 2'b00));
    endfunction

endpackage

// File: rtl/dm_master_lane.sv
// Combinational byte-lane logic for the data-memory master.
// Ports:
//   op        : latched operation
//   lane      : byte offset within the word (addr[1:0])
//   rd        : word read from data memory
//   wlow      : low 16 bits of store data
//   load_data : lane extracted and sign/zero-extended for loads
//   merged    : rd with the addressed byte/halfword replaced for SB/SH
module dm_master_lane
    import dm_master_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  lane,
    input  logic [31:0] rd,
    input  logic [15:0] wlow,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [15:0] sh;

    // Little-endian: shifting by lane*8 brings the addressed byte/half to bit 0.
    assign sh = 16'(rd >> {lane, 3'b000});

    always_comb begin
        load_data = '0;
        merged    = rd;
        unique case (op)
            OpLw:  load_data = rd;
            OpLh:  load_data = {{16{sh[15]}}, sh};
            OpLhu: load_data = {16'h0000, sh};
            OpLb:  load_data = {{24{sh[7]}}, sh[7:0]};
            OpLbu: load_data = {24'h00_0000, sh[7:0]};
            OpSw:  merged    = rd;
            OpSh: begin
                if (lane[1]) merged[31:16] = wlow;
                else         merged[15:0]  = wlow;
            end
            OpSb: begin
                unique case (lane)
                    2'd0: merged[7:0]   = wlow[7:0];
                    2'd1: merged[15:8]  = wlow[7:0];
                    2'd2: merged[23:16] = wlow[7:0];
                    2'd3: merged[31:24] = wlow[7:0];
                endcase
            end
        endcase
    end

endmodule

// File: rtl/dm_master.sv
// Data-memory master: accepts one CPU load/store at a time, performs it against a
// combinational-read word memory (read-modify-write for SB/SH) and returns a response.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   req_valid/ready/op/addr/wdata/pc : CPU request handshake and payload
//   resp_valid/ready/rdata/err       : response handshake, load data, error flag
//   dm_addr, dm_wd, dm_wr, dm_pc     : word address, write word, write strobe, latched PC
//   dm_rd                    : combinational read word at dm_addr
module dm_master
    import dm_master_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic        dm_wr,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rd
);

    state_e      state_q;
    op_e         op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] rdata_q;
    logic [31:0] merged_q;
    logic        err_q;

    op_e         op_in;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        on_bus;

    assign op_in   = op_e'(req_op);
    assign req_err = access_error(op_in, req_addr, ADDR_LIMIT);

    dm_master_lane u_lane (
        .op        (op_q),
        .lane      (addr_q[1:0]),
        .rd        (dm_rd),
        .wlow      (wdata_q[15:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            op_q     <= OpLw;
            addr_q   <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
            rdata_q  <= '0;
            merged_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_q    <= op_in;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        pc_q    <= req_pc;
                        rdata_q <= '0;
                        err_q   <= req_err;
                        state_q <= req_err ? StResp : StAccess;
                    end
                end
                StAccess: begin
                    if (is_load(op_q)) begin
                        rdata_q <= load_data;
                        state_q <= StResp;
                    end else if (op_q == OpSw) begin
                        state_q <= StResp;
                    end else begin
                        merged_q <= merged;
                        state_q  <= StWrite;
                    end
                end
                StWrite: state_q <= StResp;
                StResp: begin
                    if (resp_ready) state_q <= StIdle;
                end
            endcase
        end
    end

    assign on_bus = (state_q == StAccess) || (state_q == StWrite);

    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_rdata = (state_q == StResp) ? rdata_q : '0;
        resp_err   = (state_q == StResp) && err_q;
        dm_addr    = on_bus ? {addr_q[31:2], 2'b00} : '0;
        dm_pc      = on_bus ? pc_q : '0;
        dm_wd      = '0;
        dm_wr      = 1'b0;
        if (state_q == StAccess && op_q == OpSw) begin
            dm_wd = wdata_q;
            dm_wr = rst;
        end else if (state_q == StWrite) begin
            dm_wd = merged_q;
            dm_wr = rst;
        end
    end

endmodule

// File: doc/dm_master.md
DM_MASTER -- requirements
Module: dm_master

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 32'h0000_3000, exclusive byte-address upper bound of data memory.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  CPU access request present.
REQ-005 SHALL have port req_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port req_op  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-aligned for SH/SB.
REQ-009 SHALL have port req_pc  input  32  PC of issuing instruction.
REQ-010 SHALL have port resp_valid  output  1  response present.
REQ-011 SHALL have port resp_ready  input  1  CPU consumes response.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  misaligned or out-of-range access.
REQ-014 SHALL have ports dm_addr (output, 32, word-aligned address), dm_wd (output, 32, write word), dm_wr (output, 1, write strobe), dm_pc (output, 32, latched PC), dm_rd (input, 32, combinational read word).

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; accept = req_valid && req_ready.
REQ-017 On accept, SHALL latch op/addr/wdata/pc; if error go to RESP with resp_err=1, else go to ACCESS.
REQ-018 SHALL flag error when addr >= ADDR_LIMIT, or halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-019 SHALL drive dm_addr = {latched addr[31:2], 2'b00} in ACCESS and WRITE, else 0.
REQ-020 In ACCESS for loads, SHALL register extracted lane of dm_rd (little-endian, lane = addr[1:0]), sign-extend for LH/LB, zero-extend for LHU/LBU, then go to RESP.
REQ-021 In ACCESS for SW, SHALL assert dm_wr with dm_wd=wdata for exactly one cycle, then go to RESP.
REQ-022 In ACCESS for SH/SB, SHALL register dm_rd with selected lane replaced by wdata low bits; go to WRITE.
REQ-023 In WRITE, SHALL assert dm_wr with dm_wd=merged word for exactly one cycle, then go to RESP.
REQ-024 dm_wr SHALL never be asserted outside these cycles, nor during any cycle with rst low.
REQ-025 In RESP, SHALL hold resp_valid=1 with stable resp_rdata/resp_err until resp_ready=1, then go to IDLE.
REQ-026 Latency accept->resp_valid SHALL be 2 cycles for loads and SW, 3 for SH/SB, 1 for errors.
REQ-027 A request arriving while not IDLE SHALL be ignored (req_ready=0); no queuing.
REQ-028 dm_pc SHALL equal latched PC in ACCESS/WRITE, else 0.

Reset
REQ-029 While rst=0 at a rising edge, SHALL enter IDLE and clear all registers; resp_valid, resp_err, resp_rdata, dm_addr, dm_wd, dm_pc SHALL be 0.
REQ-030 Reset mid-operation SHALL abandon the access with no write issued and no response produced.

Structure
REQ-031 SHALL place op encoding, FSM state type and default ADDR_LIMIT in shared package dm_master_pkg.
REQ-032 SHALL place lane extract/extend/merge logic in combinational sub-module dm_master_lane.

Verification
REQ-033 LW addr 0x10 with mem[4]=0x8899AABB -> resp_rdata 0x8899AABB, resp_valid 2 cycles after accept, dm_wr never high.
REQ-034 LB addr 0x13 (mem[4]=0x8899AABB) -> 0xFFFFFF88; LBU addr 0x13 -> 0x00000088; LH addr 0x12 -> 0xFFFF8899.
REQ-035 SB addr 0x11 wdata 0x000000CC over 0x8899AABB -> single dm_wr in WRITE, dm_wd 0x8899CCBB, dm_addr 0x10, resp 3 cycles after accept.
REQ-036 LW addr 0x02, SH addr 0x01, SW addr 0x3000 -> resp_err=1 one cycle after accept, no dm_wr, resp_rdata 0.
REQ-037 resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready 0, new req_valid ignored.
REQ-038 rst low during WRITE of SH -> no dm_wr that cycle, memory unchanged, IDLE next cycle, no resp_valid.
